// File: rtl/stopwatch_bcd_n.sv
// BCD up/down stopwatch with prescaler, preset load, sticky done and lap.
// Optional lap register: define STOPWATCH_LAP_EN.
//
// Parameters:
//   DVSR      clock cycles per count tick (>= 2)
//   N_DIGITS  number of BCD digits (1..8)
// Ports:
//   clk, reset       rising-edge clock, synchronous active-high reset
//   go               1 = prescaler runs, 0 = paused
//   clr              synchronous clear of count, prescaler, done, lap
//   up               1 = count up, 0 = count down
//   load, load_val   strobe to preset digits (nibbles > 9 become 9)
//   lap              strobe to capture digits into lap_digits
//   digits           registered BCD count, nibble 0 least significant
//   lap_digits       registered captured count (0 when lap disabled)
//   tick             one-cycle pulse per count tick
//   done             sticky: up-wrap or down reached zero
module stopwatch_bcd_n #(
  parameter int DVSR     = 10000000,
  parameter int N_DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  go,
  input  logic                  clr,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] load_val,
  input  logic                  lap,
  output logic [4*N_DIGITS-1:0] digits,
  output logic [4*N_DIGITS-1:0] lap_digits,
  output logic                  tick,
  output logic                  done
);

  localparam int W  = 4 * N_DIGITS;
  localparam int PW = $clog2(DVSR);
  localparam logic [PW-1:0] PMAX = PW'(DVSR - 1);

  logic [PW-1:0] presc;
  logic [W-1:0]  nxt;
  logic [W-1:0]  sat;
  logic          carry;
  logic          wrap;

  assign tick = go & (presc == PMAX);

  // carry doubles as borrow: digit k moves only while every
  // lower digit sits at its roll-over value (9 up, 0 down)
  always_comb begin
    nxt   = digits;
    sat   = '0;
    carry = 1'b1;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (load_val[4*k +: 4] > 4'd9)
        sat[4*k +: 4] = 4'd9;
      else
        sat[4*k +: 4] = load_val[4*k +: 4];
      if (carry) begin
        if (up)
          nxt[4*k +: 4] = (digits[4*k +: 4] == 4'd9)
                          ? 4'd0 : digits[4*k +: 4] + 4'd1;
        else
          nxt[4*k +: 4] = (digits[4*k +: 4] == 4'd0)
                          ? 4'd9 : digits[4*k +: 4] - 4'd1;
      end
      if (up)
        carry = carry & (digits[4*k +: 4] == 4'd9);
      else
        carry = carry & (digits[4*k +: 4] == 4'd0);
    end
    // down count parks at zero instead of rolling to all-9
    if (!up && digits == '0)
      nxt = digits;
    wrap = up ? carry : (nxt == '0);
  end

  always_ff @(posedge clk) begin
    if (reset || clr) begin
      presc  <= '0;
      digits <= '0;
      done   <= 1'b0;
    end else if (load) begin
      presc  <= '0;
      digits <= sat;
      done   <= 1'b0;
    end else if (go) begin
      presc <= tick ? '0 : presc + PW'(1);
      if (tick) begin
        digits <= nxt;
        if (wrap)
          done <= 1'b1;
      end
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic [W-1:0] lap_q;

  always_ff @(posedge clk) begin
    if (reset || clr)
      lap_q <= '0;
    else if (lap)
      lap_q <= digits;
  end

  assign lap_digits = lap_q;
`else
  logic unused_lap;

  assign unused_lap = lap;
  assign lap_digits = '0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd_n.sv
// Self-checking bench for stopwatch_bcd_n (DVSR=4, N_DIGITS=3).
// Integer-valued reference model plus directed and random steps.
module tb_stopwatch_bcd_n;

  localparam int DVSR = 4;
  localparam int ND   = 3;

  logic        clk = 1'b0;
  logic        reset, go, clr, up, load, lap;
  logic [11:0] load_val;
  logic [11:0] digits, lap_digits;
  logic        tick, done;

  int errors = 0;
  int checks = 0;

  int m_val   = 0;
  int m_presc = 0;
  int m_lap   = 0;
  bit m_done  = 1'b0;
  bit m_ok    = 1'b0;

  always #5 clk = ~clk;

  stopwatch_bcd_n #(.DVSR(DVSR), .N_DIGITS(ND)) dut (
    .clk(clk), .reset(reset), .go(go), .clr(clr),
    .up(up), .load(load), .load_val(load_val), .lap(lap),
    .digits(digits), .lap_digits(lap_digits),
    .tick(tick), .done(done)
  );

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  function automatic int sat_val(input logic [11:0] lv);
    int r = 0;
    for (int k = ND - 1; k >= 0; k--) begin
      int n = int'(lv >> (4 * k)) & 15;
      if (n > 9) n = 9;
      r = r * 10 + n;
    end
    return r;
  endfunction

  task automatic chk(input string tag,
                     input logic [11:0] got,
                     input logic [11:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step_model(input bit u);
    if (u) begin
      m_val++;
      if (m_val == 1000) begin
        m_val  = 0;
        m_done = 1'b1;
      end
    end else begin
      if (m_val > 0) m_val--;
      if (m_val == 0) m_done = 1'b1;
    end
  endtask

  task automatic cyc(input bit g, input bit u, input bit c,
                     input bit ld, input logic [11:0] lv,
                     input bit lp, input bit r);
    bit etick;
    go = g; up = u; clr = c; load = ld;
    load_val = lv; lap = lp; reset = r;
    #1;
    etick = m_ok && g && (m_presc == DVSR - 1);
    if (m_ok) chk("tick", 12'(tick), 12'(etick));
    @(posedge clk);
    if (r || c) begin
      m_val = 0; m_presc = 0; m_done = 1'b0; m_lap = 0;
      if (r) m_ok = 1'b1;
    end else begin
`ifdef STOPWATCH_LAP_EN
      if (lp) m_lap = m_val;
`endif
      if (ld) begin
        m_val = sat_val(lv); m_presc = 0; m_done = 1'b0;
      end else if (g) begin
        if (m_presc == DVSR - 1) begin
          m_presc = 0;
          step_model(u);
        end else begin
          m_presc++;
        end
      end
    end
    #1;
    if (m_ok) begin
      chk("digits", digits, bcd(m_val));
      chk("done", 12'(done), 12'(m_done));
      chk("lap", lap_digits, bcd(m_lap));
    end
  endtask

  task automatic run(input int n, input bit u);
    for (int i = 0; i < n; i++) cyc(1, u, 0, 0, 12'h0, 0, 0);
  endtask

  initial begin
    bit ru;
    reset = 1'b1; go = 1'b0; clr = 1'b0; up = 1'b1;
    load = 1'b0; lap = 1'b0; load_val = '0;

    cyc(0, 1, 0, 0, 12'h0, 0, 1);
    chk("rst_digits", digits, 12'h000);
    chk("rst_done", 12'(done), 12'h0);

    run(40, 1);
    chk("up40", digits, 12'h010);
    chk("up40_done", 12'(done), 12'h0);

    cyc(0, 1, 0, 1, 12'h998, 0, 0);
    run(8, 1);
    chk("wrap", digits, 12'h000);
    chk("wrap_done", 12'(done), 12'h1);
    run(12, 1);
    chk("post_wrap", digits, 12'h003);
    chk("sticky", 12'(done), 12'h1);

    cyc(0, 0, 0, 1, 12'h002, 0, 0);
    run(16, 0);
    chk("down0", digits, 12'h000);
    chk("down0_done", 12'(done), 12'h1);
    cyc(0, 0, 0, 1, 12'hA5F, 0, 0);
    chk("sat", digits, 12'h959);
    chk("load_done", 12'(done), 12'h0);

    run(2, 1);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 0, 12'h0, 0, 0);
    run(2, 1);
    chk("resume", digits, 12'h960);

    cyc(0, 1, 0, 1, 12'h123, 0, 0);
    run(3, 1);
    cyc(1, 1, 1, 1, 12'h555, 0, 0);
    chk("clr_ld", digits, 12'h000);
    cyc(0, 1, 0, 1, 12'h777, 0, 0);
    cyc(1, 1, 1, 1, 12'h555, 1, 1);
    chk("rst_all", digits, 12'h000);
    chk("rst_lap", lap_digits, 12'h000);

    cyc(0, 1, 0, 1, 12'h041, 0, 0);
    run(3, 1);
    cyc(1, 1, 0, 0, 12'h0, 1, 0);
    chk("lap_tick", digits, 12'h042);
`ifdef STOPWATCH_LAP_EN
    chk("lap_val", lap_digits, 12'h041);
`else
    chk("lap_off", lap_digits, 12'h000);
`endif

    ru = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 59) == 0) ru = ~ru;
      cyc($urandom_range(0, 4) != 0, ru,
          $urandom_range(0, 149) == 0,
          $urandom_range(0, 39) == 0,
          12'($urandom),
          $urandom_range(0, 9) == 0,
          $urandom_range(0, 299) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
